// File: rtl/led_pwm_mmio.sv
// Memory-mapped five-LED PWM controller on the CPU data bus (32-byte register window).
// Optional blink register/phase counter enabled by defining LEDPWM_BLINK_EN.
module led_pwm_mmio #(
    parameter logic [31:0] BASE         = 32'h0002_0020,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic [4:0]  leds
);

    typedef enum logic [2:0] {
        REG_LEDS     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_DUTY0    = 3'd2,
        REG_DUTY1    = 3'd3,
        REG_DUTY2    = 3'd4,
        REG_DUTY3    = 3'd5,
        REG_DUTY4    = 3'd6,
        REG_BLINK    = 3'd7
    } reg_off_t;

    logic        hit;
    logic        wr_en;
    reg_off_t    off;
    logic [31:0] rd_val;
    logic [4:0]  led_en;
    logic [15:0] prescale;
    logic [7:0]  duty [5];
    logic [15:0] pre_cnt;
    logic [7:0]  pwm_cnt;
    logic        tick;
    logic [4:0]  on;
    logic        unused_bits;
`ifdef LEDPWM_BLINK_EN
    logic [4:0]  blink;
    logic [1:0]  phase;
`endif

    assign hit         = (mem_addr[31:5] == BASE[31:5]);
    assign off         = reg_off_t'(mem_addr[4:2]);
    assign wr_en       = mem_write & hit;
    assign tick        = (pre_cnt >= prescale);
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16], BASE[4:0]};

    always_comb begin
        rd_val = '0;
        case (off)
            REG_LEDS:     rd_val = {27'd0, led_en};
            REG_PRESCALE: rd_val = {16'd0, prescale};
            REG_DUTY0:    rd_val = {24'd0, duty[0]};
            REG_DUTY1:    rd_val = {24'd0, duty[1]};
            REG_DUTY2:    rd_val = {24'd0, duty[2]};
            REG_DUTY3:    rd_val = {24'd0, duty[3]};
            REG_DUTY4:    rd_val = {24'd0, duty[4]};
`ifdef LEDPWM_BLINK_EN
            REG_BLINK:    rd_val = {27'd0, blink};
`endif
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_en   <= '0;
            prescale <= PRESCALE_RST;
            for (int unsigned i = 0; i < 5; i++) duty[i] <= '1;
`ifdef LEDPWM_BLINK_EN
            blink    <= '0;
`endif
        end else if (wr_en) begin
            case (off)
                REG_LEDS:     led_en   <= mem_wdata[4:0];
                REG_PRESCALE: prescale <= mem_wdata[15:0];
                REG_DUTY0:    duty[0]  <= mem_wdata[7:0];
                REG_DUTY1:    duty[1]  <= mem_wdata[7:0];
                REG_DUTY2:    duty[2]  <= mem_wdata[7:0];
                REG_DUTY3:    duty[3]  <= mem_wdata[7:0];
                REG_DUTY4:    duty[4]  <= mem_wdata[7:0];
`ifdef LEDPWM_BLINK_EN
                REG_BLINK:    blink    <= mem_wdata[4:0];
`endif
                default: ;
            endcase
        end
    end

    // Read samples pre-edge register state, so a same-cycle store is not visible yet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_rdata <= '0;
        end else if (mem_read) begin
            mem_rdata <= hit ? rd_val : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

`ifdef LEDPWM_BLINK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase <= '0;
        end else if (tick && pwm_cnt == 8'hFF) begin
            phase <= phase + 2'd1;
        end
    end
`endif

    // Duty 0xFF is forced fully on so there is no 1/256 dark slot.
    always_comb begin
        on = '0;
        for (int unsigned n = 0; n < 5; n++) begin
            on[n] = led_en[n] & ((duty[n] == 8'hFF) | (pwm_cnt < duty[n]));
`ifdef LEDPWM_BLINK_EN
            on[n] = on[n] & (~blink[n] | phase[1]);
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            leds <= '0;
        end else begin
            leds <= on;
        end
    end

endmodule

// File: tb/tb_led_pwm_mmio.sv
// Self-checking bench for led_pwm_mmio: register table, PWM duty counts, reset and random traffic.
module tb_led_pwm_mmio;

    localparam logic [31:0] BASE = 32'h0002_0020;

    logic        clk;
    logic        resetn;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [4:0]  leds;

    int n_vec;
    int n_bad;

    // reference model state
    logic [4:0]  m_en;
    int unsigned m_presc;
    int unsigned m_duty [5];
    int unsigned m_pre;
    int unsigned m_pwm;
    logic [4:0]  m_blink;
    int unsigned m_phase;
    logic [31:0] m_rdata;
    logic [4:0]  m_leds;

    led_pwm_mmio #(.BASE(BASE), .PRESCALE_RST(16'd0)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .leds      (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic m_reset();
        m_en = '0; m_presc = 0; m_pre = 0; m_pwm = 0;
        for (int i = 0; i < 5; i++) m_duty[i] = 255;
        m_blink = '0; m_phase = 0; m_rdata = '0; m_leds = '0;
    endtask

    function automatic logic [31:0] m_regval(input int unsigned o);
        case (o)
            0: return {27'd0, m_en};
            1: return m_presc;
            2, 3, 4, 5, 6: return m_duty[o-2];
`ifdef LEDPWM_BLINK_EN
            7: return {27'd0, m_blink};
`endif
            default: return 0;
        endcase
    endfunction

    task automatic m_clock(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        bit          hit;
        int unsigned o;
        logic [4:0]  lit;
        hit = (a[31:5] == BASE[31:5]);
        o   = a[4:2];
        for (int n = 0; n < 5; n++) begin
            lit[n] = m_en[n] && (m_duty[n] == 255 || m_pwm < m_duty[n]);
`ifdef LEDPWM_BLINK_EN
            if (m_blink[n] && m_phase < 2) lit[n] = 1'b0;
`endif
        end
        if (r) m_rdata = hit ? m_regval(o) : 32'd0;
        if (m_pre >= m_presc) begin
            m_pre = 0;
            m_pwm = (m_pwm + 1) % 256;
            if (m_pwm == 0) m_phase = (m_phase + 1) % 4;
        end else begin
            m_pre++;
        end
        if (w && hit) begin
            case (o)
                0: m_en = d[4:0];
                1: m_presc = d[15:0];
                2, 3, 4, 5, 6: m_duty[o-2] = d[7:0];
`ifdef LEDPWM_BLINK_EN
                7: m_blink = d[4:0];
`endif
                default: ;
            endcase
        end
        m_leds = lit;
    endtask

    task automatic step(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        mem_write = w; mem_read = r; mem_addr = a; mem_wdata = d;
        @(posedge clk);
        m_clock(w, r, a, d);
        #1;
        check("model", {mem_rdata[26:0], leds}, {m_rdata[26:0], m_leds});
        if (mem_rdata[31:27] !== m_rdata[31:27]) check("rdata_hi", mem_rdata, m_rdata);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, BASE, 0);
    endtask

    task automatic wr(input int unsigned o, input logic [31:0] d);
        step(1, 0, BASE + o * 4, d);
    endtask

    task automatic count_on(input int bitn, input int cycles, output int hi);
        hi = 0;
        for (int i = 0; i < cycles; i++) begin
            step(0, 0, BASE, 0);
            if (leds[bitn]) hi++;
        end
    endtask

    typedef struct {
        bit          w;
        bit          r;
        logic [31:0] a;
        logic [31:0] d;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int hi;
        int guard;
        n_vec = 0; n_bad = 0;
        mem_write = 0; mem_read = 0; mem_addr = '0; mem_wdata = '0;
        resetn = 0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_leds", {27'd0, leds}, 32'd0);
            check("reset_rdata", mem_rdata, 32'd0);
        end
        resetn = 1;

        tbl[0]  = '{0, 1, 32'h0002_0028, 32'h0,         1, 32'hFF};
        tbl[1]  = '{0, 1, 32'h0002_0024, 32'h0,         1, 32'h0};
        tbl[2]  = '{1, 0, 32'h0002_0020, 32'hFFFF_FFFF, 0, 32'h0};
        tbl[3]  = '{0, 1, 32'h0002_0020, 32'h0,         1, 32'h1F};
        tbl[4]  = '{1, 0, 32'h0002_0004, 32'h0,         0, 32'h0};
        tbl[5]  = '{0, 1, 32'h0002_0020, 32'h0,         1, 32'h1F};
        tbl[6]  = '{0, 1, 32'h0002_0004, 32'h0,         1, 32'h0};
        tbl[7]  = '{1, 0, 32'h0002_002C, 32'h1234_5680, 0, 32'h0};
        tbl[8]  = '{0, 1, 32'h0002_002E, 32'h0,         1, 32'h80};
        tbl[9]  = '{1, 0, 32'h0002_003C, 32'h7,         0, 32'h0};
`ifdef LEDPWM_BLINK_EN
        tbl[10] = '{0, 1, 32'h0002_003C, 32'h0,         1, 32'h7};
`else
        tbl[10] = '{0, 1, 32'h0002_003C, 32'h0,         1, 32'h0};
`endif
        tbl[11] = '{1, 1, 32'h0002_0024, 32'h5,         1, 32'h0};
        tbl[12] = '{0, 1, 32'h0002_0024, 32'h0,         1, 32'h5};
        tbl[13] = '{0, 0, 32'h0002_0024, 32'h0,         1, 32'h5};
        tbl[14] = '{1, 0, 32'h0002_0024, 32'h0,         0, 32'h0};
        tbl[15] = '{1, 0, 32'h0002_002C, 32'hFF,        0, 32'h0};
        tbl[16] = '{1, 0, 32'h0002_003C, 32'h0,         0, 32'h0};
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
            if (tbl[i].chk) check($sformatf("tbl%0d", i), mem_rdata, tbl[i].exp);
        end

        // LED latency: store at one edge, visible on leds after the following edge
        wr(0, 32'h0);
        idle(1);
        wr(0, 32'h1F);
        check("leds_lat0", {27'd0, leds}, 32'h0);
        idle(1);
        check("leds_lat1", {27'd0, leds}, 32'h1F);

        // duty 64 at prescale 0 then 3
        wr(0, 32'h1); wr(2, 32'd64); wr(1, 32'd0); idle(1);
        count_on(0, 256, hi);
        check("duty64_p0", hi, 32'd64);
        wr(1, 32'd3); idle(1);
        count_on(0, 1024, hi);
        check("duty64_p3", hi, 32'd256);

        // duty 0 never lights; miss store changes nothing
        wr(1, 32'd0); wr(0, 32'h2); wr(3, 32'd0); idle(1);
        count_on(1, 512, hi);
        check("duty0_off", hi, 32'd0);
        step(1, 0, 32'h0002_0004, 32'hFF);
        step(0, 1, BASE, 0);
        check("miss_leds", mem_rdata, 32'h2);
        step(0, 1, BASE + 4, 0);
        check("miss_presc", mem_rdata, 32'h0);

        // async reset mid-period
        wr(0, 32'h1); wr(2, 32'd128); step(0, 1, BASE, 0);
        guard = 0;
        while (leds[0] !== 1'b1 && guard < 300) begin idle(1); guard++; end
        idle(20);
        #3 resetn = 0;
        #1;
        m_reset();
        check("midrst_leds", {27'd0, leds}, 32'd0);
        check("midrst_rdata", mem_rdata, 32'd0);
        @(posedge clk); #1;
        check("midrst_hold", {27'd0, leds}, 32'd0);
        resetn = 1;
        wr(0, 32'h1); wr(2, 32'd128); idle(300);
        count_on(0, 256, hi);
        check("duty128", hi, 32'd128);

`ifdef LEDPWM_BLINK_EN
        wr(1, 32'd0); wr(2, 32'hFF); wr(0, 32'h1); wr(7, 32'h1); idle(1);
        count_on(0, 2048, hi);
        check("blink", hi, 32'd1024);
`endif

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            int unsigned o;
            o = $urandom_range(0, 7);
            a = BASE + o * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = a + 32'h20;
            d = $urandom;
            if (o == 1) d = $urandom_range(0, 3);
            if (o == 0 || o == 7) d[4:0] = 5'h1F & $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
